// File: rtl/vec_beat_sequencer_if.sv
// Decode/Memory to Execute handshake bundle for the vector beat sequencer.
//   master : drives the issue request, memory-ready and flush; observes beats.
//   slave  : the sequencer; consumes the requests and presents beats/stall/done.
// Signals:
//   IssueD, VLenD, IsMemD  - vector instruction request from Decode
//   MemReadyM              - memory stage finished the outstanding beat
//   FlushSeq               - pipeline flush, aborts any sequence
//   BeatValidE, BeatIdxE, LaneMaskE, LastBeatE - per-beat Execute issue
//   SeqStall               - hold Fetch/Decode
//   DoneS                  - one-cycle normal-completion pulse
interface vec_beat_sequencer_if #(
    parameter int unsigned LANES = 4,
    parameter int unsigned VL_W  = 8
);
    logic             IssueD;
    logic [VL_W-1:0]  VLenD;
    logic             IsMemD;
    logic             MemReadyM;
    logic             FlushSeq;
    logic             BeatValidE;
    logic [VL_W-1:0]  BeatIdxE;
    logic [LANES-1:0] LaneMaskE;
    logic             LastBeatE;
    logic             SeqStall;
    logic             DoneS;

    modport master (
        output IssueD, VLenD, IsMemD, MemReadyM, FlushSeq,
        input  BeatValidE, BeatIdxE, LaneMaskE, LastBeatE, SeqStall, DoneS
    );

    modport slave (
        input  IssueD, VLenD, IsMemD, MemReadyM, FlushSeq,
        output BeatValidE, BeatIdxE, LaneMaskE, LastBeatE, SeqStall, DoneS
    );
endinterface

// File: rtl/vec_beat_sequencer.sv
// Vector beat sequencer: splits one vector instruction from Decode into
// ceil(VL/LANES) Execute beats of LANES elements, stalling Fetch/Decode while
// a sequence is in flight. Memory ops wait for MemReadyM between beats.
// Ports:
//   clk   - pipeline clock, rising edge
//   rst_n - asynchronous active-low reset
//   bus   - vec_beat_sequencer_if slave modport (issue, beats, stall, done)
module vec_beat_sequencer #(
    parameter int unsigned LANES = 4,
    parameter int unsigned VL_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vec_beat_sequencer_if.slave   bus
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StMwait = 2'd2;

    // Index step and its widened copy for wrap-free comparisons.
    localparam logic [VL_W-1:0] LaneStep  = VL_W'(LANES);
    localparam logic [VL_W:0]   LaneStepW = (VL_W + 1)'(LANES);

    logic [1:0]       state_q, state_d;
    logic [VL_W-1:0]  vl_q, vl_d;
    logic [VL_W-1:0]  idx_q, idx_d;
    logic             mem_q, mem_d;
    logic             done_q, done_d;

    logic             in_run;
    logic             last_beat;
    logic [LANES-1:0] lane_mask;

    assign in_run = (state_q == StRun);

    // Evaluated in VL_W+1 bits so Idx+LANES cannot wrap when VL is near 2^VL_W.
    assign last_beat = (({1'b0, idx_q} + LaneStepW) >= {1'b0, vl_q});

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_mask[i] = in_run && (({1'b0, idx_q} + (VL_W + 1)'(i)) < {1'b0, vl_q});
        end
    end

    always_comb begin
        state_d = state_q;
        vl_d    = vl_q;
        idx_d   = idx_q;
        mem_d   = mem_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                // A zero-length issue is accepted as a no-op: nothing latched.
                if (!bus.FlushSeq && bus.IssueD && (bus.VLenD != '0)) begin
                    vl_d    = bus.VLenD;
                    mem_d   = bus.IsMemD;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (bus.FlushSeq) begin
                    state_d = StIdle;
                end else if (mem_q) begin
                    state_d = StMwait;
                end else if (last_beat) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end else begin
                    idx_d = idx_q + LaneStep;
                end
            end
            StMwait: begin
                // Flush has priority over a simultaneous memory completion.
                if (bus.FlushSeq) begin
                    state_d = StIdle;
                end else if (bus.MemReadyM) begin
                    if (last_beat) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        idx_d   = idx_q + LaneStep;
                        state_d = StRun;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            vl_q    <= '0;
            idx_q   <= '0;
            mem_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vl_q    <= vl_d;
            idx_q   <= idx_d;
            mem_q   <= mem_d;
            done_q  <= done_d;
        end
    end

    // Moore outputs; Idx is masked outside RUN so stale indices never leak.
    assign bus.BeatValidE = in_run;
    assign bus.BeatIdxE   = in_run ? idx_q : '0;
    assign bus.LaneMaskE  = lane_mask;
    assign bus.LastBeatE  = in_run && last_beat;
    assign bus.SeqStall   = (state_q != StIdle);
    assign bus.DoneS      = done_q;

endmodule

// File: tb/tb_vec_beat_sequencer.sv
module tb_vec_beat_sequencer;

    localparam int unsigned LANES = 4;
    localparam int unsigned VL_W  = 8;

    typedef struct packed {
        logic [7:0] idx;
        logic [3:0] mask;
        logic       last;
    } beat_t;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    int   done_pending;
    beat_t exp_q[$];

    vec_beat_sequencer_if #(.LANES(LANES), .VL_W(VL_W)) bus ();

    vec_beat_sequencer #(.LANES(LANES), .VL_W(VL_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic push(input int idx, input int mask, input int last);
        beat_t b;
        b.idx  = 8'(idx);
        b.mask = 4'(mask);
        b.last = last[0];
        exp_q.push_back(b);
    endtask

    task automatic drain(input string name);
        chk({name, "_beats_left"}, exp_q.size(), 0);
        chk({name, "_done_left"}, done_pending, 0);
        exp_q.delete();
        done_pending = 0;
    endtask

    // Monitor: pops expected beats and done pulses whenever the DUT presents them.
    always @(negedge clk) begin : mon
        beat_t e;
        if (rst_n) begin
            if (bus.BeatValidE) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_beat: got idx %0d, expected no beat",
                             bus.BeatIdxE);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_idx", int'(bus.BeatIdxE), int'(e.idx));
                    chk("beat_mask", int'(bus.LaneMaskE), int'(e.mask));
                    chk("beat_last", int'(bus.LastBeatE), int'(e.last));
                end
            end else begin
                chk("idle_mask_last", int'({bus.LaneMaskE, bus.LastBeatE}), 0);
            end
            if (bus.DoneS) begin
                tests_run++;
                if (done_pending == 0) begin
                    tests_failed++;
                    $display("FAIL unexpected_done: got DoneS=1, expected 0");
                end else begin
                    done_pending--;
                end
            end
        end
    end

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        done_pending  = 0;
        rst_n         = 1'b0;
        bus.IssueD    = 1'b0;
        bus.VLenD     = '0;
        bus.IsMemD    = 1'b0;
        bus.MemReadyM = 1'b0;
        bus.FlushSeq  = 1'b0;
        step();
        sample();
        chk("rst_valid", int'(bus.BeatValidE), 0);
        chk("rst_idx", int'(bus.BeatIdxE), 0);
        chk("rst_mask", int'(bus.LaneMaskE), 0);
        chk("rst_last", int'(bus.LastBeatE), 0);
        chk("rst_stall", int'(bus.SeqStall), 0);
        chk("rst_done", int'(bus.DoneS), 0);
        step();
        rst_n = 1'b1;
        step();

        // Non-mem VL=10: beats at 0/4/8, DoneS one cycle after the last beat.
        push(0, 4'b1111, 0);
        push(4, 4'b1111, 0);
        push(8, 4'b0011, 1);
        done_pending = 1;
        bus.IssueD = 1'b1;
        bus.VLenD  = 8'd10;
        bus.IsMemD = 1'b0;
        sample();
        chk("nm_accept_stall", int'(bus.SeqStall), 0);
        step();
        bus.IssueD = 1'b0;
        sample();
        chk("nm_stall_n1", int'(bus.SeqStall), 1);
        step();
        step();
        sample();
        chk("nm_stall_n3", int'(bus.SeqStall), 1);
        chk("nm_last_n3", int'(bus.LastBeatE), 1);
        step();
        sample();
        chk("nm_done_n4", int'(bus.DoneS), 1);
        chk("nm_stall_n4", int'(bus.SeqStall), 0);
        step();
        sample();
        chk("nm_done_n5", int'(bus.DoneS), 0);
        drain("nonmem10");

        // Mem VL=5: MemReadyM low two wait cycles, high on the third.
        step();
        push(0, 4'b1111, 0);
        push(4, 4'b0001, 1);
        done_pending = 1;
        bus.IssueD = 1'b1;
        bus.VLenD  = 8'd5;
        bus.IsMemD = 1'b1;
        step();
        bus.IssueD = 1'b0;
        bus.IsMemD = 1'b0;
        step();
        sample();
        chk("mem_wait_stall", int'(bus.SeqStall), 1);
        step();
        step();
        bus.MemReadyM = 1'b1;
        step();
        sample();
        chk("mem_beat2_valid", int'(bus.BeatValidE), 1);
        step();
        sample();
        chk("mem_n6_valid", int'(bus.BeatValidE), 0);
        step();
        bus.MemReadyM = 1'b0;
        sample();
        chk("mem_done_n7", int'(bus.DoneS), 1);
        step();
        drain("mem5");

        // Flush at the second beat of a VL=16 sequence.
        push(0, 4'b1111, 0);
        push(4, 4'b1111, 0);
        bus.IssueD = 1'b1;
        bus.VLenD  = 8'd16;
        step();
        bus.IssueD = 1'b0;
        step();
        bus.FlushSeq = 1'b1;
        step();
        bus.FlushSeq = 1'b0;
        sample();
        chk("flush_run_stall", int'(bus.SeqStall), 0);
        step();
        step();
        drain("flush_run");

        // Flush together with MemReadyM in MWAIT.
        push(0, 4'b1111, 0);
        bus.IssueD = 1'b1;
        bus.VLenD  = 8'd8;
        bus.IsMemD = 1'b1;
        step();
        bus.IssueD = 1'b0;
        bus.IsMemD = 1'b0;
        step();
        bus.FlushSeq  = 1'b1;
        bus.MemReadyM = 1'b1;
        step();
        bus.FlushSeq  = 1'b0;
        bus.MemReadyM = 1'b0;
        sample();
        chk("flush_mwait_stall", int'(bus.SeqStall), 0);
        step();
        step();
        drain("flush_mwait");

        // Flush in IDLE blocks an issue.
        bus.FlushSeq = 1'b1;
        bus.IssueD   = 1'b1;
        bus.VLenD    = 8'd4;
        step();
        bus.FlushSeq = 1'b0;
        bus.IssueD   = 1'b0;
        sample();
        chk("flush_idle_stall", int'(bus.SeqStall), 0);
        step();
        drain("flush_idle");

        // VL=0 is a no-op.
        bus.IssueD = 1'b1;
        bus.VLenD  = 8'd0;
        step();
        bus.IssueD = 1'b0;
        sample();
        chk("vl0_stall", int'(bus.SeqStall), 0);
        step();
        sample();
        chk("vl0_stall2", int'(bus.SeqStall), 0);
        drain("vl0");

        // VL=255: 64 beats, last at 252 with mask 0111; IssueD ignored mid-run.
        for (int k = 0; k < 64; k++) begin
            push(k * 4, (k == 63) ? 4'b0111 : 4'b1111, (k == 63) ? 1 : 0);
        end
        done_pending = 1;
        bus.IssueD = 1'b1;
        bus.VLenD  = 8'd255;
        step();
        bus.VLenD = 8'd3;
        for (int k = 0; k < 64; k++) begin
            if (k == 10) bus.IssueD = 1'b0;
            step();
        end
        sample();
        chk("vl255_done", int'(bus.DoneS), 1);
        chk("vl255_stall", int'(bus.SeqStall), 0);
        step();
        drain("vl255");

        // Reset mid-RUN abandons the sequence without DoneS.
        push(0, 4'b1111, 0);
        push(4, 4'b1111, 0);
        bus.IssueD = 1'b1;
        bus.VLenD  = 8'd16;
        step();
        bus.IssueD = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", int'(bus.BeatValidE), 0);
        chk("midrst_idx", int'(bus.BeatIdxE), 0);
        chk("midrst_stall", int'(bus.SeqStall), 0);
        step();
        step();
        rst_n = 1'b1;
        sample();
        chk("postrst_valid", int'(bus.BeatValidE), 0);
        chk("postrst_idx", int'(bus.BeatIdxE), 0);
        chk("postrst_mask", int'(bus.LaneMaskE), 0);
        chk("postrst_stall", int'(bus.SeqStall), 0);
        chk("postrst_done", int'(bus.DoneS), 0);
        step();
        step();
        drain("midrst");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
